// File: rtl/fir_pkg.sv
// Shared FSM encoding and fixed-point helpers for the transposed-form FIR chain.
// The round/saturate helpers work at RS_W bits so any ACC_W up to that fits.
package fir_pkg;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWAP} fir_state_e;

  localparam int RS_W = 128;

  function automatic int acc_w_min(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  function automatic logic signed [RS_W-1:0] round_shift(input logic signed [RS_W-1:0] y,
                                                         input int shift);
    logic signed [RS_W-1:0] half;
    half = (shift > 0) ? (RS_W'(1) <<< (shift - 1)) : '0;
    return (y + half) >>> shift;
  endfunction

  function automatic logic signed [RS_W-1:0] sat_hi(input int data_w);
    return (RS_W'(1) <<< (data_w - 1)) - RS_W'(1);
  endfunction

  function automatic logic signed [RS_W-1:0] round_sat(input logic signed [RS_W-1:0] y,
                                                       input int shift, input int data_w);
    logic signed [RS_W-1:0] r, hi, lo;
    r  = round_shift(y, shift);
    hi = sat_hi(data_w);
    lo = ~hi;
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

  function automatic logic round_sat_flag(input logic signed [RS_W-1:0] y,
                                          input int shift, input int data_w);
    logic signed [RS_W-1:0] r, hi;
    r  = round_shift(y, shift);
    hi = sat_hi(data_w);
    return (r > hi) || (r < ~hi);
  endfunction

endpackage

// File: rtl/fir_tap_pe.sv
// One transposed-form tap: acc_out <= acc_in + w*x when enabled, zeroed by clear.
module fir_tap_pe #(
  parameter int DATA_W = 24,
  parameter int COEF_W = 18,
  parameter int ACC_W  = 48
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] w,
  input  logic signed [ACC_W-1:0]  acc_in,
  output logic signed [ACC_W-1:0]  acc_out
);

  logic signed [ACC_W-1:0] prod_p0;

  assign prod_p0 = ACC_W'(x) * ACC_W'(w);

  // stage p0 -> p1: accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out <= '0;
    end else if (clear) begin
      acc_out <= '0;
    end else if (enable) begin
      acc_out <= acc_in + prod_p0;
    end
  end

endmodule

// File: rtl/fir_systolic_chain.sv
// Transposed-form systolic FIR with double-buffered coefficients, a drain/swap
// commit FSM and a rounded, saturated valid/ready output register.
module fir_systolic_chain
  import fir_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int COEF_W    = 18,
  parameter int ACC_W     = 48,
  parameter int TAPS      = 8,
  parameter int OUT_SHIFT = 17,
  localparam int AW       = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_sat,
  input  logic                     out_ready,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     coef_commit,
  output logic                     commit_done
);

  if ((TAPS < 2) || (ACC_W < acc_w_min(DATA_W, COEF_W, TAPS))) begin : g_bad_params
    $error("fir_systolic_chain: TAPS must be >= 2 and ACC_W wide enough for the full sum");
  end

  fir_state_e state, state_nx;

  logic signed [COEF_W-1:0] shadow [TAPS];
  logic signed [COEF_W-1:0] active [TAPS];
  logic signed [ACC_W-1:0]  acc    [1:TAPS];
  logic signed [ACC_W-1:0]  y_p0;
  logic signed [DATA_W-1:0] rnd_p0;
  logic                     sat_p0;
  logic                     advance, out_free, swap, addr_ok;

  assign out_free = !out_valid || out_ready;
  assign advance  = in_valid && in_ready;
  assign swap     = (state == ST_SWAP);
  assign addr_ok  = ({1'b0, coef_addr} < (AW+1)'(TAPS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    commit_done = 1'b0;
    unique case (state)
      ST_RUN: begin
        in_ready = out_free;
        if (coef_commit) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_free) state_nx = ST_SWAP;
      end
      ST_SWAP: begin
        commit_done = 1'b1;
        state_nx    = ST_RUN;
      end
      default: state_nx = ST_RUN;
    endcase
  end

  // Copy happens with the pre-write shadow value, so a write in the swap cycle lands after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (swap) active <= shadow;
      if (coef_we && addr_ok) shadow[coef_addr] <= coef_data;
    end
  end

  assign acc[TAPS] = '0;

  for (genvar k = 1; k < TAPS; k++) begin : g_tap
    fir_tap_pe #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
    ) u_pe (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (advance),
      .clear   (swap),
      .x       (in_data),
      .w       (active[k]),
      .acc_in  (acc[k+1]),
      .acc_out (acc[k])
    );
  end

  // stage p0: tap 0 product joins the chain, then round and clamp
  assign y_p0   = acc[1] + ACC_W'(in_data) * ACC_W'(active[0]);
  assign rnd_p0 = DATA_W'(round_sat(RS_W'(y_p0), OUT_SHIFT, DATA_W));
  assign sat_p0 = round_sat_flag(RS_W'(y_p0), OUT_SHIFT, DATA_W);

  // stage p0 -> p1: output register, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (advance) begin
      out_valid <= 1'b1;
      out_data  <= rnd_p0;
      out_sat   <= sat_p0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_systolic_chain.sv
// Bench for fir_systolic_chain: two instances (OUT_SHIFT 0 and 1) share one stimulus
// stream and are compared every cycle against a convolution-level reference model.
module tb_fir_systolic_chain;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic               out_ready = 1'b0;
  logic               coef_we = 1'b0;
  logic [1:0]         coef_addr = '0;
  logic signed [17:0] coef_data = '0;
  logic               coef_commit = 1'b0;

  logic               in_ready0, out_valid0, out_sat0, commit_done0;
  logic signed [15:0] out_data0;
  logic               in_ready1, out_valid1, out_sat1, commit_done1;
  logic signed [15:0] out_data1;

  fir_systolic_chain #(.DATA_W(16), .COEF_W(18), .ACC_W(40), .TAPS(4), .OUT_SHIFT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_data(out_data0), .out_sat(out_sat0), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_commit(coef_commit), .commit_done(commit_done0)
  );

  fir_systolic_chain #(.DATA_W(16), .COEF_W(18), .ACC_W(40), .TAPS(4), .OUT_SHIFT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_sat(out_sat1), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_commit(coef_commit), .commit_done(commit_done1)
  );

  int n_vec = 0;
  int n_fail = 0;

  // reference model state: coefficient banks, accepted-sample history (newest first)
  longint act [4];
  longint shd [4];
  longint hist[$];
  int     m_st = 0;   // 0 run, 1 drain, 2 swap
  bit     m_ov = 1'b0;
  longint m_od [2];
  bit     m_os [2];

  task automatic chk(input string nm, input logic signed [63:0] got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic rsat(input longint y, input int s, output longint r, output bit sat);
    r = y;
    if (s > 0) r = (y + (longint'(1) <<< (s - 1))) >>> s;
    sat = 1'b0;
    if (r > 32767) begin
      r = 32767;
      sat = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      sat = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      act[k] = 0;
      shd[k] = 0;
    end
    hist.delete();
    m_st = 0;
    m_ov = 1'b0;
    m_od[0] = 0; m_od[1] = 0;
    m_os[0] = 1'b0; m_os[1] = 1'b0;
  endtask

  // Inputs are set by the caller shortly after a rising edge; this checks the
  // combinational handshake, crosses one edge, updates the model and checks outputs.
  task automatic tick();
    bit rdy, adv, ov_old;
    longint y;
    rdy = (m_st == 0) && (!m_ov || out_ready);
    #1;
    chk("in_ready0", in_ready0, rdy);
    chk("in_ready1", in_ready1, rdy);
    chk("commit_done0", commit_done0, (m_st == 2));
    chk("commit_done1", commit_done1, (m_st == 2));
    @(posedge clk);
    adv = in_valid && rdy;
    ov_old = m_ov;
    if (adv) begin
      hist.push_front(longint'(in_data));
      if (hist.size() > 4) void'(hist.pop_back());
      y = 0;
      foreach (hist[k]) y += act[k] * hist[k];
      m_ov = 1'b1;
      rsat(y, 0, m_od[0], m_os[0]);
      rsat(y, 1, m_od[1], m_os[1]);
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    case (m_st)
      0: if (coef_commit) m_st = 1;
      1: if (!ov_old || out_ready) m_st = 2;
      default: begin
        act = shd;
        hist.delete();
        m_st = 0;
      end
    endcase
    if (coef_we) shd[coef_addr] = longint'(coef_data);
    #1;
    chk("out_valid0", out_valid0, m_ov);
    chk("out_valid1", out_valid1, m_ov);
    if (m_ov) begin
      chk("out_data0", out_data0, m_od[0]);
      chk("out_sat0", out_sat0, m_os[0]);
      chk("out_data1", out_data1, m_od[1]);
      chk("out_sat1", out_sat1, m_os[1]);
    end
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
    for (int i = 0; i < 8 && m_st != 0; i++) tick();
    if (m_st != 0) chk("commit_timeout", m_st, 0);
  endtask

  task automatic load_coefs(input int a, input int b, input int c, input int d);
    int w[4];
    w = '{a, b, c, d};
    in_valid = 1'b0;
    out_ready = 1'b1;
    coef_commit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      coef_we = 1'b1;
      coef_addr = 2'(i);
      coef_data = 18'(w[i]);
      tick();
    end
    coef_we = 1'b0;
    commit();
  endtask

  typedef struct {
    int g;
    int x;
    int y0;
    bit s0;
    int y1;
    bit s1;
  } vec_t;

  vec_t tbl [10];
  int   wset [3][4];
  int   exp_bp [4];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int g_cur;
    wset = '{'{1, 2, 3, 4}, '{1, 0, 0, 0}, '{2, 0, 0, 0}};
    tbl[0] = '{0,    100,    100, 1'b0,     50, 1'b0};
    tbl[1] = '{0,      0,    200, 1'b0,    100, 1'b0};
    tbl[2] = '{0,      0,    300, 1'b0,    150, 1'b0};
    tbl[3] = '{0,      0,    400, 1'b0,    200, 1'b0};
    tbl[4] = '{0,      0,      0, 1'b0,      0, 1'b0};
    tbl[5] = '{1,      3,      3, 1'b0,      2, 1'b0};
    tbl[6] = '{1,     -3,     -3, 1'b0,     -1, 1'b0};
    tbl[7] = '{1,      1,      1, 1'b0,      1, 1'b0};
    tbl[8] = '{2,  20000,  32767, 1'b1,  20000, 1'b0};
    tbl[9] = '{2, -20000, -32768, 1'b1, -20000, 1'b0};
    exp_bp = '{200, 300, 400, 0};
    model_reset();

    // reset state
    #2;
    chk("rst_out_valid0", out_valid0, 0);
    chk("rst_out_data0", out_data0, 0);
    chk("rst_out_sat0", out_sat0, 0);
    chk("rst_in_ready0", in_ready0, 1);
    chk("rst_commit_done0", commit_done0, 0);
    chk("rst_out_valid1", out_valid1, 0);
    chk("rst_out_data1", out_data1, 0);
    chk("rst_in_ready1", in_ready1, 1);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // impulse, rounding and saturation vectors
    g_cur = -1;
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].g != g_cur) begin
        g_cur = tbl[i].g;
        load_coefs(wset[g_cur][0], wset[g_cur][1], wset[g_cur][2], wset[g_cur][3]);
      end
      in_valid = 1'b1;
      out_ready = 1'b1;
      in_data = 16'(tbl[i].x);
      tick();
      chk("tbl_valid", out_valid0, 1);
      chk("tbl_data0", out_data0, tbl[i].y0);
      chk("tbl_sat0", out_sat0, tbl[i].s0);
      chk("tbl_data1", out_data1, tbl[i].y1);
      chk("tbl_sat1", out_sat1, tbl[i].s1);
    end
    in_valid = 1'b0;

    // backpressure: stall three cycles after the first output
    load_coefs(1, 2, 3, 4);
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = 16'sd100;
    tick();
    chk("bp_first", out_data0, 100);
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) begin
      #1 chk("bp_in_ready", in_ready0, 0);
      tick();
      chk("bp_hold_data", out_data0, 100);
      chk("bp_hold_valid", out_valid0, 1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_resume", out_data0, exp_bp[i]);
    end

    // commit mid-stream while the output is stalled
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      coef_we = 1'b1;
      coef_addr = 2'(i);
      coef_data = (i == 0) ? 18'sd5 : (i == 1) ? 18'sd1 : 18'sd0;
      tick();
    end
    coef_we = 1'b0;
    in_valid = 1'b1;
    in_data = 16'sd50;
    out_ready = 1'b0;
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
    chk("cm_old_coef", out_data0, 50);
    in_data = 16'sd9;
    repeat (2) begin
      #1;
      chk("cm_drain_in_ready", in_ready0, 0);
      chk("cm_drain_no_done", commit_done0, 0);
      tick();
      chk("cm_drain_hold", out_data0, 50);
    end
    out_ready = 1'b1;
    tick();
    chk("cm_drained", out_valid0, 0);
    coef_we = 1'b1;
    coef_addr = 2'd0;
    coef_data = 18'sd7;
    #1;
    chk("cm_done_pulse", commit_done0, 1);
    chk("cm_swap_in_ready", in_ready0, 0);
    tick();
    coef_we = 1'b0;
    chk("cm_done_clear", commit_done0, 0);
    in_data = 16'sd10;
    tick();
    chk("cm_new_w0", out_data0, 50);
    in_data = '0;
    tick();
    chk("cm_new_w1", out_data0, 10);
    tick();
    chk("cm_no_history", out_data0, 0);
    in_valid = 1'b0;
    commit();
    in_valid = 1'b1;
    in_data = 16'sd10;
    tick();
    chk("cm_second_commit", out_data0, 70);
    in_valid = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data = 16'($urandom);
      coef_we = ($urandom_range(0, 7) == 0);
      coef_addr = 2'($urandom);
      coef_data = ($urandom_range(0, 1) == 1) ? 18'($urandom) : 18'($urandom_range(0, 63) - 32);
      coef_commit = ($urandom_range(0, 19) == 0);
      tick();
    end
    coef_we = 1'b0;
    coef_commit = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && m_st != 0; i++) tick();

    // asynchronous reset mid-stream
    in_data = 16'sd1234;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid0", out_valid0, 0);
    chk("arst_out_valid1", out_valid1, 0);
    chk("arst_out_data0", out_data0, 0);
    chk("arst_in_ready0", in_ready0, 1);
    model_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data = 16'sd1000;
    tick();
    chk("arst_impulse_valid", out_valid0, 1);
    chk("arst_impulse_zero", out_data0, 0);
    in_data = '0;
    repeat (3) begin
      tick();
      chk("arst_tail_zero", out_data0, 0);
    end
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
